countdown_timer: RTL and testbench



---
 rtl/countdown_timer.sv | 164 ++++++++++++++++
 tb/tb_countdown_timer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Match-clock BCD down-counter with start/pause/resume control and time-up pulse.
// Optional blinking low-time warning is built only when COUNTDOWN_WARN_EN is defined.
module countdown_timer #(
    parameter int DIGITS        = 2,
    parameter int TICKS_PER_SEC = 50000000,
    parameter int WARN_LEVEL    = 10
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  loadN,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  start,
    input  logic                  pause,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  time_up,
    output logic                  expired,
    output logic                  warn
);

    localparam int PS_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [PS_W-1:0]     prescaler, prescaler_nxt;
    logic [4*DIGITS-1:0] count_nxt;
    logic                time_up_nxt;

    // Digits above 9 are forced to 9 so the counter never holds a non-BCD value.
    function automatic logic [4*DIGITS-1:0] bcd_clamp(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    function automatic logic [4*DIGITS-1:0] bcd_dec(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            prescaler <= '0;
            count     <= '0;
            time_up   <= 1'b0;
            running   <= 1'b0;
            expired   <= 1'b0;
        end else begin
            state     <= state_nxt;
            prescaler <= prescaler_nxt;
            count     <= count_nxt;
            time_up   <= time_up_nxt;
            running   <= (state_nxt == RUN);
            expired   <= (state_nxt == EXPIRED);
        end
    end

    // Priority: load > pause > start > tick. Pause freezes the prescaler so a resume loses no time.
    always_comb begin
        state_nxt     = state;
        prescaler_nxt = prescaler;
        count_nxt     = count;
        time_up_nxt   = 1'b0;
        if (!loadN) begin
            count_nxt     = bcd_clamp(load_value);
            prescaler_nxt = '0;
            state_nxt     = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!pause && start && (count != '0)) state_nxt = RUN;
                end
                RUN: begin
                    if (pause) begin
                        state_nxt = PAUSED;
                    end else if (prescaler == PS_LAST) begin
                        prescaler_nxt = '0;
                        count_nxt     = bcd_dec(count);
                        if (count_nxt == '0) begin
                            state_nxt   = EXPIRED;
                            time_up_nxt = 1'b1;
                        end
                    end else begin
                        prescaler_nxt = prescaler + PS_W'(1);
                    end
                end
                PAUSED: begin
                    if (start && !pause) state_nxt = RUN;
                end
                EXPIRED: begin
                    state_nxt = EXPIRED;
                end
            endcase
        end
    end

`ifdef COUNTDOWN_WARN_EN
    function automatic int bcd_to_int(input logic [4*DIGITS-1:0] v);
        int r;
        r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            r = r * 10 + int'(v[4*i +: 4]);
        end
        return r;
    endfunction

    function automatic logic in_warn_range(input logic [4*DIGITS-1:0] v);
        return (v != '0) && (bcd_to_int(v) <= WARN_LEVEL);
    endfunction

    logic warn_nxt;
    logic active_now, active_nxt;

    assign active_now = (state == RUN) || (state == PAUSED);
    assign active_nxt = (state_nxt == RUN) || (state_nxt == PAUSED);

    // Blink starts high on the first in-range value, then flips on each decrement.
    always_comb begin
        warn_nxt = 1'b0;
        if (state_nxt == EXPIRED) begin
            warn_nxt = 1'b1;
        end else if (active_nxt && in_warn_range(count_nxt)) begin
            if (!(active_now && in_warn_range(count))) warn_nxt = 1'b1;
            else if (count_nxt != count)               warn_nxt = ~warn;
            else                                       warn_nxt = warn;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) warn <= 1'b0;
        else         warn <= warn_nxt;
    end
`else
    // WARN_LEVEL only matters when the blink logic is built.
    logic unused_warn_cfg;
    assign unused_warn_cfg = (WARN_LEVEL < 0);
    assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer (DIGITS=2, TICKS_PER_SEC=4, WARN_LEVEL=3).
// Warn expectations follow COUNTDOWN_WARN_EN the same way the design does.
module tb_countdown_timer;

    localparam int DIGITS = 2;

`ifdef COUNTDOWN_WARN_EN
    localparam logic WON = 1'b1;
`else
    localparam logic WON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetN;
    logic       loadN;
    logic [7:0] load_value;
    logic       start;
    logic       pause;
    logic [7:0] count;
    logic       running;
    logic       time_up;
    logic       expired;
    logic       warn;

    int total_cnt = 0;
    int pass_cnt  = 0;

    countdown_timer #(
        .DIGITS        (DIGITS),
        .TICKS_PER_SEC (4),
        .WARN_LEVEL    (3)
    ) dut (
        .clk        (clk),
        .resetN     (resetN),
        .loadN      (loadN),
        .load_value (load_value),
        .start      (start),
        .pause      (pause),
        .count      (count),
        .running    (running),
        .time_up    (time_up),
        .expired    (expired),
        .warn       (warn)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       loadN;
        logic [7:0] lv;
        logic       start;
        logic       pause;
        logic [7:0] cnt;
        logic       run;
        logic       tu;
        logic       ex;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic ld, input logic [7:0] lv, input logic st,
                                input logic pa, input logic [7:0] c, input logic r,
                                input logic t, input logic e);
        vec_t v;
        v.loadN = ld; v.lv = lv; v.start = st; v.pause = pa;
        v.cnt = c; v.run = r; v.tu = t; v.ex = e;
        return v;
    endfunction

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic status(input string tag, input logic [7:0] c, input logic r,
                          input logic t, input logic e, input logic w);
        chk8({tag, " count"}, count, c);
        chk1({tag, " running"}, running, r);
        chk1({tag, " time_up"}, time_up, t);
        chk1({tag, " expired"}, expired, e);
        chk1({tag, " warn"}, warn, w);
    endtask

    task automatic do_load(input logic [7:0] v);
        loadN = 1'b0; load_value = v;
        cyc(1);
        loadN = 1'b1; load_value = 8'h00;
    endtask

    task automatic do_start;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk(0, 8'hFA, 0, 0, 8'h99, 0, 0, 0);
        vecs[1]  = mk(0, 8'h3C, 0, 0, 8'h39, 0, 0, 0);
        vecs[2]  = mk(0, 8'hA7, 0, 0, 8'h97, 0, 0, 0);
        vecs[3]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        vecs[4]  = mk(1, 8'h55, 1, 0, 8'h00, 0, 0, 0);
        vecs[5]  = mk(1, 8'h55, 0, 0, 8'h00, 0, 0, 0);
        vecs[6]  = mk(0, 8'h12, 0, 0, 8'h12, 0, 0, 0);
        vecs[7]  = mk(1, 8'h34, 1, 0, 8'h12, 1, 0, 0);
        vecs[8]  = mk(1, 8'h77, 0, 0, 8'h12, 1, 0, 0);
        vecs[9]  = mk(1, 8'h00, 0, 0, 8'h12, 1, 0, 0);
        vecs[10] = mk(1, 8'h00, 0, 0, 8'h12, 1, 0, 0);
        vecs[11] = mk(1, 8'h00, 0, 0, 8'h11, 1, 0, 0);
        vecs[12] = mk(1, 8'h00, 0, 0, 8'h11, 1, 0, 0);
        vecs[13] = mk(1, 8'h00, 0, 0, 8'h11, 1, 0, 0);
        vecs[14] = mk(1, 8'h00, 0, 0, 8'h11, 1, 0, 0);
        vecs[15] = mk(1, 8'h00, 0, 0, 8'h10, 1, 0, 0);
        vecs[16] = mk(1, 8'h00, 0, 0, 8'h10, 1, 0, 0);
        vecs[17] = mk(1, 8'h00, 0, 0, 8'h10, 1, 0, 0);
        vecs[18] = mk(1, 8'h00, 0, 0, 8'h10, 1, 0, 0);
        vecs[19] = mk(1, 8'h00, 0, 0, 8'h09, 1, 0, 0);
        vecs[20] = mk(1, 8'h99, 1, 0, 8'h09, 1, 0, 0);

        resetN = 1'b0; loadN = 1'b1; load_value = 8'h00; start = 1'b0; pause = 1'b0;
        cyc(2);
        status("reset", 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        resetN = 1'b1;
        cyc(1);
        status("post-reset idle", 8'h00, 0, 0, 0, 0);

        // Table: clamping, zero start, basic run with borrow.
        for (int i = 0; i < 21; i++) begin
            loadN = vecs[i].loadN; load_value = vecs[i].lv;
            start = vecs[i].start; pause = vecs[i].pause;
            cyc(1);
            status($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].run, vecs[i].tu, vecs[i].ex, 1'b0);
        end
        loadN = 1'b1; start = 1'b0; pause = 1'b0;

        // Run to zero: one-cycle time_up, then EXPIRED ignores start.
        do_load(8'h02);
        do_start();
        chk1("exp start running", running, 1'b1);
        cyc(3);
        chk8("exp before tick1", count, 8'h02);
        cyc(1);
        chk8("exp tick1", count, 8'h01);
        cyc(3);
        chk1("exp no early time_up", time_up, 1'b0);
        cyc(1);
        status("exp reach zero", 8'h00, 0, 1, 1, WON);
        cyc(1);
        status("exp after pulse", 8'h00, 0, 0, 1, WON);
        start = 1'b1;
        cyc(2);
        status("exp start ignored", 8'h00, 0, 0, 1, WON);
        start = 1'b0;

        // Pause mid-prescaler, then resume; continue into the warn range.
        do_load(8'h05);
        do_start();
        cyc(2);
        pause = 1'b1;
        cyc(10);
        status("paused", 8'h05, 0, 0, 0, 0);
        start = 1'b1;
        cyc(1);
        chk1("start+pause stays paused", running, 1'b0);
        pause = 1'b0;
        cyc(1);
        start = 1'b0;
        chk1("resume running", running, 1'b1);
        cyc(1);
        chk8("resume 1 clk", count, 8'h05);
        cyc(1);
        status("resume 2 clk", 8'h04, 1, 0, 0, 0);
        cyc(4);
        status("at 03", 8'h03, 1, 0, 0, WON);
        cyc(4);
        status("at 02", 8'h02, 1, 0, 0, 1'b0);
        cyc(4);
        status("at 01", 8'h01, 1, 0, 0, WON);
        cyc(4);
        status("at 00", 8'h00, 0, 1, 1, WON);

        // Load during RUN restarts the prescaler.
        do_load(8'h45);
        do_start();
        cyc(2);
        do_load(8'h30);
        status("reload mid-run", 8'h30, 0, 0, 0, 0);
        do_start();
        cyc(3);
        chk8("reload 3 clk", count, 8'h30);
        cyc(1);
        chk8("reload 4 clk", count, 8'h29);

        // Asynchronous reset between clock edges.
        cyc(1);
        #2;
        resetN = 1'b0;
        #1;
        status("async reset", 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        resetN = 1'b1;
        cyc(2);
        status("after async reset", 8'h00, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
